alu_rs_cluster: RTL

- Parametrised successor to the adders reservation-station unit: NUM_RS tagged reservation stations feeding one pipelined ALU of configurable latency.
- Each RS captures pending operands by snooping the CDB broadcast.
- Ready stations dispatch oldest-first; each completed result is held in its RS until it is granted the CDB.
- Sits between the issue stage and the CDB arbiter.

---
 rtl/alu_rs_cluster.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_rs_cluster.sv
// NUM_RS tagged reservation stations sharing one LAT-stage pipelined ALU; each RS holds its result
// until granted the CDB. Define ALU_CMP_EN to enable opcodes 010/011 (signed/unsigned less-than).
module alu_rs_cluster #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_RS   = 4,
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned BASE_TAG = 1,
  parameter int unsigned LAT      = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue,
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              A_invalid,
  input  logic              B_invalid,
  input  logic              snoop_valid,
  input  logic [TAG_W-1:0]  snoop_tag,
  input  logic [DATA_W-1:0] snoop_data,
  input  logic              CDB_xmit,
  output logic [DATA_W-1:0] CDB_data,
  output logic [TAG_W-1:0]  CDB_source,
  output logic              CDB_write,
  output logic              CDB_rts,
  output logic              available,
  output logic [TAG_W-1:0]  RS_available,
  output logic [TAG_W-1:0]  issued,
  output logic [TAG_W-1:0]  RS_executing,
  output logic              error
);

  localparam int unsigned IDX_W = $clog2(NUM_RS);
  localparam int unsigned AGE_W = $clog2(NUM_RS) + 1;

  typedef enum logic [2:0] {StFree, StWait, StReady, StExec, StDone} rs_state_e;

  rs_state_e         st_q     [NUM_RS];
  logic [2:0]        op_q     [NUM_RS];
  logic [DATA_W-1:0] a_q      [NUM_RS];
  logic [DATA_W-1:0] b_q      [NUM_RS];
  logic [DATA_W-1:0] res_q    [NUM_RS];
  logic [TAG_W-1:0]  a_tag_q  [NUM_RS];
  logic [TAG_W-1:0]  b_tag_q  [NUM_RS];
  logic              a_vld_q  [NUM_RS];
  logic              b_vld_q  [NUM_RS];
  logic [AGE_W-1:0]  age_q    [NUM_RS];

  logic              pipe_vld_q [LAT];
  logic [IDX_W-1:0]  pipe_idx_q [LAT];
  logic [DATA_W-1:0] pipe_res_q [LAT];

  logic              free_found, rdy_found, done_found;
  logic [IDX_W-1:0]  free_idx, rdy_idx, done_idx;
  logic [AGE_W-1:0]  rdy_age, done_age, busy_cnt, new_age;
  logic [NUM_RS-1:0] a_hit, b_hit;
  logic              legal_op, issue_ok, byp_a, byp_b, new_a_vld, new_b_vld;
  logic [DATA_W-1:0] new_a, new_b, disp_res;

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
`ifdef ALU_CMP_EN
      3'b010:  r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011:  r = {{(DATA_W-1){1'b0}}, (a < b)};
`endif
      3'b100:  r = a | b;
      3'b101:  r = a & b;
      3'b110:  r = ~a;
      3'b111:  r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [TAG_W-1:0] idx_tag(input logic [IDX_W-1:0] idx);
    return TAG_W'(BASE_TAG) + TAG_W'(idx);
  endfunction

  // Ages are compacted on every free, so busy RSs always hold 0..busy_cnt-1; smaller is older.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    rdy_age    = '0;
    done_found = 1'b0;
    done_idx   = '0;
    done_age   = '0;
    busy_cnt   = '0;
    a_hit      = '0;
    b_hit      = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (st_q[i] == StFree) begin
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = IDX_W'(i);
        end
      end else begin
        busy_cnt = busy_cnt + AGE_W'(1);
      end
      if (st_q[i] == StReady && (!rdy_found || age_q[i] < rdy_age)) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
        rdy_age   = age_q[i];
      end
      if (st_q[i] == StDone && (!done_found || age_q[i] < done_age)) begin
        done_found = 1'b1;
        done_idx   = IDX_W'(i);
        done_age   = age_q[i];
      end
      a_hit[i] = snoop_valid && st_q[i] == StWait && !a_vld_q[i] && snoop_tag == a_tag_q[i];
      b_hit[i] = snoop_valid && st_q[i] == StWait && !b_vld_q[i] && snoop_tag == b_tag_q[i];
    end
  end

  always_comb begin
    legal_op = (opcode[5:3] == 3'b000);
`ifndef ALU_CMP_EN
    if (opcode[2:1] == 2'b01) legal_op = 1'b0;
`endif
  end

  assign issue_ok  = issue && free_found && legal_op;
  assign byp_a     = A_invalid && snoop_valid && (snoop_tag == A[TAG_W-1:0]);
  assign byp_b     = B_invalid && snoop_valid && (snoop_tag == B[TAG_W-1:0]);
  assign new_a_vld = !A_invalid || byp_a;
  assign new_b_vld = !B_invalid || byp_b;
  assign new_a     = byp_a ? snoop_data : A;
  assign new_b     = byp_b ? snoop_data : B;
  assign new_age   = busy_cnt - (CDB_write ? AGE_W'(1) : AGE_W'(0));
  assign disp_res  = alu(op_q[rdy_idx], a_q[rdy_idx], b_q[rdy_idx]);

  assign available    = free_found;
  assign RS_available = free_found ? idx_tag(free_idx) : '0;
  assign CDB_rts      = done_found;
  assign CDB_data     = done_found ? res_q[done_idx] : '0;
  assign CDB_source   = done_found ? idx_tag(done_idx) : '0;
  assign CDB_write    = CDB_xmit && done_found;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_RS; i++) begin
        st_q[i]  <= StFree;
        age_q[i] <= '0;
      end
      for (int s = 0; s < LAT; s++) begin
        pipe_vld_q[s] <= 1'b0;
        pipe_idx_q[s] <= '0;
      end
      issued       <= '0;
      error        <= 1'b0;
      RS_executing <= '0;
    end else begin
      issued       <= issue_ok ? RS_available : '0;
      error        <= issue && !issue_ok;
      RS_executing <= rdy_found ? idx_tag(rdy_idx) : '0;

      // The ALU result is computed on entry and simply carried through the remaining stages.
      pipe_vld_q[0] <= rdy_found;
      pipe_idx_q[0] <= rdy_idx;
      pipe_res_q[0] <= disp_res;
      for (int s = 1; s < LAT; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_idx_q[s] <= pipe_idx_q[s-1];
        pipe_res_q[s] <= pipe_res_q[s-1];
      end

      for (int i = 0; i < NUM_RS; i++) begin
        if (CDB_write && st_q[i] != StFree && age_q[i] > done_age) begin
          age_q[i] <= age_q[i] - AGE_W'(1);
        end
        unique case (st_q[i])
          StFree: begin
            if (issue_ok && free_idx == IDX_W'(i)) begin
              st_q[i]    <= (new_a_vld && new_b_vld) ? StReady : StWait;
              op_q[i]    <= opcode[2:0];
              a_q[i]     <= new_a;
              b_q[i]     <= new_b;
              a_tag_q[i] <= A[TAG_W-1:0];
              b_tag_q[i] <= B[TAG_W-1:0];
              a_vld_q[i] <= new_a_vld;
              b_vld_q[i] <= new_b_vld;
              age_q[i]   <= new_age;
            end
          end
          StWait: begin
            if (a_hit[i]) begin
              a_q[i]     <= snoop_data;
              a_vld_q[i] <= 1'b1;
            end
            if (b_hit[i]) begin
              b_q[i]     <= snoop_data;
              b_vld_q[i] <= 1'b1;
            end
            if ((a_vld_q[i] || a_hit[i]) && (b_vld_q[i] || b_hit[i])) st_q[i] <= StReady;
          end
          StReady: begin
            if (rdy_found && rdy_idx == IDX_W'(i)) st_q[i] <= StExec;
          end
          StExec: begin
            if (pipe_vld_q[LAT-1] && pipe_idx_q[LAT-1] == IDX_W'(i)) begin
              res_q[i] <= pipe_res_q[LAT-1];
              st_q[i]  <= StDone;
            end
          end
          StDone: begin
            if (CDB_write && done_idx == IDX_W'(i)) st_q[i] <= StFree;
          end
          default: st_q[i] <= StFree;
        endcase
      end
    end
  end

endmodule
